// File: rtl/banked_latch_mem.sv
// banked_latch_mem
//   Byte-wide storage of RAM_BYTES words organised as RAM_BYTES/LANES banks
//   of LANES bytes. An access of 1, 2 or 4 bytes is split into beats of up to
//   LANES bytes on consecutive edges; addresses wrap modulo RAM_BYTES. After
//   reset the storage is cleared one bank per cycle while busy is high.
//
// Ports
//   clk           in   1          sole clock, rising edge
//   rst           in   1          synchronous reset, active-high
//   addr_in       in   ADDR_BITS  byte address of the access
//   data_in       in   32         write data (bottom 8/16/32 bits valid)
//   data_write_n  in   2          11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_read_n   in   2          same encoding, read
//   data_out      out  32         read data, registered
//   data_ready    out  1          one-cycle pulse after the last beat
//   busy          out  1          initial clear in progress

// banked_latch_mem_lane
//   One byte lane of a beat: works out which storage byte the lane touches,
//   where that byte sits in the 32-bit data word, and whether the lane takes
//   part in the current access.
//
// Ports
//   i_base    in   ADDR_BITS  start address of the access
//   i_beat    in   2          beat index k
//   i_nbytes  in   3          bytes touched per beat, min(S, LANES)
//   i_wdata   in   32         write data word
//   o_addr    out  ADDR_BITS  storage byte address for this lane
//   o_pos     out  2          byte position in the data word
//   o_act     out  1          lane takes part in this beat
//   o_wbyte   out  8          write byte for this lane
module banked_latch_mem_lane #(
    parameter int ADDR_BITS = 6,
    parameter int LANES     = 2,
    parameter int LANE      = 0
) (
    input  logic [ADDR_BITS-1:0] i_base,
    input  logic [1:0]           i_beat,
    input  logic [2:0]           i_nbytes,
    input  logic [31:0]          i_wdata,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic [1:0]           o_pos,
    output logic                 o_act,
    output logic [7:0]           o_wbyte
);
    // Offset k*LANES+LANE; it stays below 4 whenever the lane is active, and
    // the address add truncates to ADDR_BITS so it wraps around the storage.
    assign o_pos   = 2'(int'(i_beat) * LANES + LANE);
    assign o_addr  = i_base + ADDR_BITS'(int'(i_beat) * LANES + LANE);
    assign o_act   = (3'(LANE) < i_nbytes);
    assign o_wbyte = i_wdata[o_pos*8 +: 8];
endmodule

module banked_latch_mem #(
    parameter int RAM_BYTES = 64,
    parameter int ADDR_BITS = 6,
    parameter int LANES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [31:0]          data_in,
    input  logic [1:0]           data_write_n,
    input  logic [1:0]           data_read_n,
    output logic [31:0]          data_out,
    output logic                 data_ready,
    output logic                 busy
);
    localparam int NUM_BANKS = RAM_BYTES / LANES;
    localparam int PTR_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int LANE_LG   = $clog2(LANES);
    localparam logic [2:0]       LANES_W   = 3'(LANES);
    localparam logic [PTR_W-1:0] LAST_BANK = PTR_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [1:0]                  r_beat, w_beat_nxt;
    logic [PTR_W-1:0]            r_ptr, w_ptr_nxt;
    logic                        r_ready;
    logic [3:0][7:0]             r_dout, w_dout_nxt;
    logic [RAM_BYTES-1:0][7:0]   r_mem, w_mem_nxt;

    logic                        w_wr_req, w_rd_req, w_req;
    logic [1:0]                  w_enc;
    logic [2:0]                  w_size, w_nb;
    logic [1:0]                  w_last_beat, w_beat;
    logic                        w_last, w_do_beat, w_mem_we, w_out_ld, w_clr;

    logic [LANES-1:0][ADDR_BITS-1:0] w_lane_addr;
    logic [LANES-1:0][1:0]           w_lane_pos;
    logic [LANES-1:0]                w_lane_act;
    logic [LANES-1:0][7:0]           w_lane_wbyte, w_lane_rbyte;

    // Request decode; a write wins over a simultaneous read.
    assign w_wr_req = (data_write_n != 2'b11);
    assign w_rd_req = (data_read_n != 2'b11);
    assign w_req    = w_wr_req || w_rd_req;
    assign w_enc    = w_wr_req ? data_write_n : data_read_n;

    always_comb begin
        w_size = 3'd1;
        case (w_enc)
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            2'b10:   w_size = 3'd4;
            default: w_size = 3'd1;
        endcase
    end

    // Bytes per beat and index of the last beat, N-1 = max(1, S/LANES)-1.
    assign w_nb        = (w_size < LANES_W) ? w_size : LANES_W;
    assign w_last_beat = (w_size > LANES_W) ? 2'((w_size >> LANE_LG) - 3'd1) : 2'd0;
    assign w_beat      = (r_state == ST_ACTIVE) ? r_beat : 2'd0;
    assign w_last      = (w_beat == w_last_beat);

    // Beat 0 happens on the IDLE edge that sees the request.
    assign w_do_beat = w_req && !rst && ((r_state == ST_IDLE) || (r_state == ST_ACTIVE));
    assign w_mem_we  = w_do_beat && w_wr_req;
    assign w_out_ld  = w_do_beat && !w_wr_req;
    assign w_clr     = (r_state == ST_INIT) && !rst;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        banked_latch_mem_lane #(
            .ADDR_BITS (ADDR_BITS),
            .LANES     (LANES),
            .LANE      (l)
        ) u_lane (
            .i_base   (addr_in),
            .i_beat   (w_beat),
            .i_nbytes (w_nb),
            .i_wdata  (data_in),
            .o_addr   (w_lane_addr[l]),
            .o_pos    (w_lane_pos[l]),
            .o_act    (w_lane_act[l]),
            .o_wbyte  (w_lane_wbyte[l])
        );
        assign w_lane_rbyte[l] = r_mem[w_lane_addr[l]];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_INIT: begin
                if (r_ptr == LAST_BANK) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (w_req) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                        w_beat_nxt  = 2'd1;
                    end
                end
            end
            ST_ACTIVE: begin
                // A dropped request aborts; bytes already stored remain.
                if (!w_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_beat_nxt = r_beat + 2'd1;
                end
            end
            ST_DONE: begin
                // Park here until the requester releases both strobes.
                if (!w_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Storage update: bank clear during INIT, lane writes during a beat.
    always_comb begin
        w_mem_nxt = r_mem;
        if (w_clr) begin
            for (int o = 0; o < LANES; o++) begin
                w_mem_nxt[ADDR_BITS'(int'(r_ptr) * LANES + o)] = 8'h00;
            end
        end
        if (w_mem_we) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_lane_act[l]) begin
                    w_mem_nxt[w_lane_addr[l]] = w_lane_wbyte[l];
                end
            end
        end
    end

    // Read data: beat 0 zeroes bytes beyond the access size, every beat
    // fills its own byte positions; other bytes hold their value.
    always_comb begin
        w_dout_nxt = r_dout;
        if (w_out_ld) begin
            if (w_beat == 2'd0) begin
                for (int p = 0; p < 4; p++) begin
                    if (3'(p) >= w_size) begin
                        w_dout_nxt[p] = 8'h00;
                    end
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (w_lane_act[l]) begin
                    w_dout_nxt[w_lane_pos[l]] = w_lane_rbyte[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_beat  <= 2'd0;
            r_ptr   <= '0;
            r_ready <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_do_beat && w_last;
            r_dout  <= w_dout_nxt;
        end
    end

    // Storage has no reset of its own; INIT clears it after every reset.
    always_ff @(posedge clk) begin
        r_mem <= w_mem_nxt;
    end

    assign data_out   = r_dout;
    assign data_ready = r_ready;
    assign busy       = (r_state == ST_INIT);
endmodule

// File: tb/tb_banked_latch_mem.sv
// tb_banked_latch_mem
//   Three instances (LANES = 1, 2, 4) share one request bus. A byte-array
//   model per instance tracks storage and data_out from the access rules.
module tb_banked_latch_mem;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       addr_in;
    logic [31:0]      data_in;
    logic [1:0]       data_write_n, data_read_n;
    logic [2:0][31:0] dout;
    logic [2:0]       rdy, bsy;

    int n_tot = 0;
    int n_bad = 0;

    logic [7:0]  m_mem [3][64];
    logic [31:0] m_dout [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        banked_latch_mem #(
            .RAM_BYTES (64),
            .ADDR_BITS (6),
            .LANES     (1 << g)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .addr_in      (addr_in),
            .data_in      (data_in),
            .data_write_n (data_write_n),
            .data_read_n  (data_read_n),
            .data_out     (dout[g]),
            .data_ready   (rdy[g]),
            .busy         (bsy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] e);
        return (e == 2'b00) ? 1 : (e == 2'b01) ? 2 : 4;
    endfunction

    function automatic int beats_of(input int s, input int lanes);
        return (s > lanes) ? s / lanes : 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 64; b++) m_mem[i][b] = 8'h00;
            m_dout[i] = 32'h0;
        end
    endtask

    // Full transaction: hold the request 'hold' cycles, then release it.
    task automatic txn(input logic [1:0] wn, input logic [1:0] rn, input logic [5:0] a,
                       input logic [31:0] d, input int hold, input string tag);
        int first [3];
        int cnt   [3];
        int s;
        logic [31:0] rd;
        data_write_n = wn;
        data_read_n  = rn;
        addr_in      = a;
        data_in      = d;
        for (int i = 0; i < 3; i++) begin
            first[i] = 0;
            cnt[i]   = 0;
        end
        for (int c = 1; c <= hold; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (rdy[i]) begin
                    cnt[i]++;
                    if (first[i] == 0) first[i] = c;
                end
            end
        end
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        @(posedge clk); #1;
        s = size_of((wn != 2'b11) ? wn : rn);
        for (int i = 0; i < 3; i++) begin
            if (wn != 2'b11) begin
                for (int p = 0; p < s; p++) m_mem[i][(a + p) % 64] = d[p*8 +: 8];
            end else begin
                rd = 32'h0;
                for (int p = 0; p < s; p++) rd[p*8 +: 8] = m_mem[i][(a + p) % 64];
                m_dout[i] = rd;
            end
            chk($sformatf("%s_L%0d_lat", tag, 1 << i), 32'(first[i]), 32'(beats_of(s, 1 << i)));
            chk($sformatf("%s_L%0d_pulses", tag, 1 << i), 32'(cnt[i]), 32'd1);
            chk($sformatf("%s_L%0d_dout", tag, 1 << i), dout[i], m_dout[i]);
        end
    endtask

    task automatic wait_init(input string tag);
        int done_at [3];
        for (int i = 0; i < 3; i++) done_at[i] = 0;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (done_at[i] == 0 && !bsy[i]) done_at[i] = e;
            end
            if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_L%0d_busy_cycles", tag, 1 << i), 32'(done_at[i]), 32'(64 >> i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  wn, rn, enc;
        int          kind, cnt [3];
        logic [5:0]  a;
        logic [31:0] d;

        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        addr_in      = '0;
        data_in      = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_dout", dout[i], 32'h0);
            chk("rst_ready", 32'(rdy[i]), 32'd0);
            chk("rst_busy", 32'(bsy[i]), 32'd1);
        end
        rst = 1'b0;
        wait_init("init");
        model_clear();

        // Idle read of a cleared location.
        txn(2'b11, 2'b10, 6'h10, 32'h0, 5, "rd_zero");

        // 32-bit write, read-back and single byte read.
        txn(2'b10, 2'b11, 6'h08, 32'hDEADBEEF, 5, "wr32");
        txn(2'b11, 2'b10, 6'h08, 32'h0, 5, "rd32");
        for (int i = 0; i < 3; i++) chk("rd32_val", dout[i], 32'hDEADBEEF);
        txn(2'b11, 2'b00, 6'h0B, 32'h0, 5, "rd8");
        for (int i = 0; i < 3; i++) chk("rd8_val", dout[i], 32'h000000DE);

        // Wrap-around write and per-byte read-back.
        txn(2'b10, 2'b11, 6'h3E, 32'h11223344, 5, "wrap_wr");
        txn(2'b11, 2'b00, 6'h3E, 32'h0, 5, "wrap_b0");
        for (int i = 0; i < 3; i++) chk("wrap_3E", dout[i], 32'h44);
        txn(2'b11, 2'b00, 6'h3F, 32'h0, 5, "wrap_b1");
        for (int i = 0; i < 3; i++) chk("wrap_3F", dout[i], 32'h33);
        txn(2'b11, 2'b00, 6'h00, 32'h0, 5, "wrap_b2");
        for (int i = 0; i < 3; i++) chk("wrap_00", dout[i], 32'h22);
        txn(2'b11, 2'b00, 6'h01, 32'h0, 5, "wrap_b3");
        for (int i = 0; i < 3; i++) chk("wrap_01", dout[i], 32'h11);

        // Latency sweep with the request held 10 cycles.
        txn(2'b11, 2'b10, 6'h3E, 32'h0, 10, "sweep");
        for (int i = 0; i < 3; i++) chk("sweep_val", dout[i], 32'h11223344);

        // Simultaneous requests: write done, data_out untouched.
        txn(2'b10, 2'b10, 6'h20, 32'hA5A55A5A, 5, "both");
        txn(2'b11, 2'b10, 6'h20, 32'h0, 5, "both_rd");
        for (int i = 0; i < 3; i++) chk("both_val", dout[i], 32'hA5A55A5A);

        // Abort after one beat: only the first min(4, LANES) bytes land.
        data_write_n = 2'b10;
        data_read_n  = 2'b11;
        addr_in      = 6'h30;
        data_in      = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) if (rdy[i]) cnt[i]++;
        data_write_n = 2'b11;
        repeat (2) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (rdy[i]) cnt[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_L%0d_pulses", 1 << i), 32'(cnt[i]), (i == 2) ? 32'd1 : 32'd0);
            for (int p = 0; p < ((1 << i) < 4 ? (1 << i) : 4); p++) m_mem[i][6'h30 + p] = data_in[p*8 +: 8];
        end
        txn(2'b11, 2'b10, 6'h30, 32'h0, 5, "abort_rd");

        // Reset in the middle of a 32-bit write.
        txn(2'b10, 2'b11, 6'h04, 32'h0BADF00D, 5, "pre_rst");
        data_write_n = 2'b10;
        addr_in      = 6'h05;
        data_in      = 32'h87654321;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_ready", 32'(rdy[i]), 32'd0);
            chk("mid_rst_busy", 32'(bsy[i]), 32'd1);
            chk("mid_rst_dout", dout[i], 32'h0);
        end
        data_write_n = 2'b11;
        rst = 1'b0;
        wait_init("reinit");
        model_clear();
        for (int w = 0; w < 16; w++) txn(2'b11, 2'b10, 6'(w * 4), 32'h0, 5, "clr_rd");

        // Random traffic against the model.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            enc  = 2'($urandom_range(0, 2));
            a    = 6'($urandom_range(0, 63));
            d    = $urandom;
            wn   = 2'b11;
            rn   = 2'b11;
            if (kind == 0) wn = enc;
            else if (kind == 1) rn = enc;
            else begin
                wn = enc;
                rn = 2'($urandom_range(0, 2));
            end
            txn(wn, rn, a, d, 5, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
